// File: rtl/clk_gen_ctrl.sv
//==============================================================================
// Module   : clk_gen_ctrl
// Summary  : Multi-channel programmable clock-enable generator with lock gate,
//            glitch-free divide updates and per-channel reset release.
//            Optional phase alignment: define CLK_GEN_PHASE_ALIGN_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module clk_gen_ctrl #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 8,
    parameter int DIV_INIT    = 1,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [CHANNELS*DIV_W-1:0] div_i,
    input  logic [CHANNELS-1:0]       div_load_i,
    input  logic                      sync_i,
    output logic [CHANNELS-1:0]       clk_en_o,
    output logic [CHANNELS-1:0]       clk_div_o,
    output logic                      locked_o,
    output logic [CHANNELS-1:0]       rst_n_o
);

    localparam int               LOCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO  = '0;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                locked_q, locked_d;

    logic [DIV_W-1:0]    div_q  [CHANNELS];
    logic [DIV_W-1:0]    div_d  [CHANNELS];
    logic [DIV_W-1:0]    cnt_q  [CHANNELS];
    logic [DIV_W-1:0]    cnt_d  [CHANNELS];
    logic [DIV_W-1:0]    pend_q [CHANNELS];
    logic [DIV_W-1:0]    pend_d [CHANNELS];
    logic [CHANNELS-1:0] pend_v_q, pend_v_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] tgl_q, tgl_d;
    logic [CHANNELS-1:0] rls_q, rls_d;

    logic                align;

`ifdef CLK_GEN_PHASE_ALIGN_EN
    assign align = sync_i & locked_q;
`else
    logic unused_sync;
    assign unused_sync = sync_i;
    assign align       = 1'b0;
`endif

    // Lock counter stops once locked; locked stays high until reset.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (!locked_q) begin
            lock_cnt_d = lock_cnt_q + LOCK_ONE;
            if (lock_cnt_q == LOCK_LAST) begin
                locked_d = 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            div_d[c]    = div_q[c];
            cnt_d[c]    = cnt_q[c];
            pend_d[c]   = pend_q[c];
            pend_v_d[c] = pend_v_q[c];
            en_d[c]     = 1'b0;
            tgl_d[c]    = tgl_q[c];
            rls_d[c]    = rls_q[c] | en_q[c];

            if (align) begin
                cnt_d[c] = DIV_ZERO;
                tgl_d[c] = 1'b0;
                if (pend_v_q[c]) begin
                    div_d[c]    = pend_q[c];
                    pend_v_d[c] = 1'b0;
                end
            end else if (locked_q) begin
                if (div_q[c] == DIV_ZERO) begin
                    cnt_d[c] = DIV_ZERO;
                    tgl_d[c] = 1'b0;
                    if (pend_v_q[c]) begin
                        div_d[c]    = pend_q[c];
                        pend_v_d[c] = 1'b0;
                    end
                end else if (cnt_q[c] == div_q[c] - DIV_ONE) begin
                    // New ratios only take effect on a period boundary.
                    cnt_d[c] = DIV_ZERO;
                    en_d[c]  = 1'b1;
                    tgl_d[c] = ~tgl_q[c];
                    if (pend_v_q[c]) begin
                        div_d[c]    = pend_q[c];
                        pend_v_d[c] = 1'b0;
                        if (pend_q[c] == DIV_ZERO) begin
                            tgl_d[c] = 1'b0;
                        end
                    end
                end else begin
                    cnt_d[c] = cnt_q[c] + DIV_ONE;
                end
            end

            // A load after the apply above leaves the newer value pending.
            if (div_load_i[c]) begin
                pend_d[c]   = div_i[c*DIV_W +: DIV_W];
                pend_v_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            pend_v_q   <= '0;
            en_q       <= '0;
            tgl_q      <= '0;
            rls_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                div_q[c]  <= DIV_RESET;
                cnt_q[c]  <= DIV_ZERO;
                pend_q[c] <= DIV_ZERO;
            end
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            pend_v_q   <= pend_v_d;
            en_q       <= en_d;
            tgl_q      <= tgl_d;
            rls_q      <= rls_d;
            for (int c = 0; c < CHANNELS; c++) begin
                div_q[c]  <= div_d[c];
                cnt_q[c]  <= cnt_d[c];
                pend_q[c] <= pend_d[c];
            end
        end
    end

    assign clk_en_o  = en_q;
    assign clk_div_o = tgl_q;
    assign locked_o  = locked_q;
    assign rst_n_o   = rls_q;

endmodule

`default_nettype wire
